// File: rtl/neuron_ctrl_if.sv
// ============================================================================
// neuron_ctrl_if: activation stream, weight ROM and result bus of one neuron.
// Rev 1.0
// ============================================================================
`default_nettype none

interface neuron_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
);
  logic                    start;
  logic [DATA_WIDTH-1:0]   in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic [ADDR_WIDTH-1:0]   w_addr;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [2*DATA_WIDTH-1:0] bias;
  logic [2*DATA_WIDTH-1:0] acc_out;
  logic                    busy;
  logic                    out_valid;

  modport master (
    output start, in_data, in_valid, w_data, bias,
    input  in_ready, w_addr, acc_out, busy, out_valid
  );

  modport slave (
    input  start, in_data, in_valid, w_data, bias,
    output in_ready, w_addr, acc_out, busy, out_valid
  );
endinterface

`default_nettype wire

// File: rtl/neuron_ctrl.sv
// ============================================================================
// neuron_ctrl: multiply-accumulate sequencer for one fixed-point neuron.
// Rev 1.0
// ============================================================================
`default_nettype none

module neuron_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_INPUTS = 784,
  parameter int ADDR_WIDTH = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  neuron_ctrl_if.slave bus
);
  localparam int ACC_WIDTH = 2 * DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0]       LAST_IDX = ADDR_WIDTH'(NUM_INPUTS - 1);
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX  = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN  = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ACC  = 3'd1,
    BIAS = 3'd2,
    ACT  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t                      state_q, state_d;
  logic [ADDR_WIDTH-1:0]       cnt_q, cnt_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;

  logic                        accept;
  logic                        last;
  logic [ADDR_WIDTH-1:0]       cnt_inc;
  logic signed [ACC_WIDTH-1:0] product;
  logic signed [ACC_WIDTH-1:0] addend;
  logic signed [ACC_WIDTH:0]   sum;
  logic signed [ACC_WIDTH-1:0] sum_sat;
  logic [ADDR_WIDTH-1:0]       w_addr;
  logic                        in_ready;
  logic                        out_valid;

  assign accept  = (state_q == ACC) && bus.in_valid;
  assign last    = (cnt_q == LAST_IDX);
  assign cnt_inc = cnt_q + ADDR_WIDTH'(1);
  assign product = ACC_WIDTH'($signed(bus.in_data)) * ACC_WIDTH'($signed(bus.w_data));
  assign addend  = (state_q == BIAS) ? $signed(bus.bias) : product;

  // One guard bit: overflow shows up as disagreement between the two top bits.
  assign sum     = {addend[ACC_WIDTH-1], addend} + {acc_q[ACC_WIDTH-1], acc_q};
  assign sum_sat = (sum[ACC_WIDTH] != sum[ACC_WIDTH-1])
                 ? (sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX)
                 : sum[ACC_WIDTH-1:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    w_addr    = '0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = ACC;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      ACC: begin
        in_ready = 1'b1;
        w_addr   = cnt_q;
        // Prefetch the next weight so the ROM output lines up with the next accept.
        if (accept) begin
          acc_d  = sum_sat;
          cnt_d  = cnt_inc;
          w_addr = last ? '0 : cnt_inc;
          if (last) begin
            state_d = BIAS;
          end
        end
      end
      BIAS: begin
        acc_d   = sum_sat;
        state_d = ACT;
      end
      ACT: begin
        state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.w_addr    = w_addr;
  assign bus.acc_out   = acc_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = out_valid;
endmodule

`default_nettype wire

// File: tb/tb_neuron_ctrl.sv
// ============================================================================
// tb_neuron_ctrl: randomized and directed checks of neuron_ctrl against a model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_neuron_ctrl;
  localparam int DW = 16;
  localparam int N  = 4;
  localparam int AW = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  neuron_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  neuron_ctrl #(.DATA_WIDTH(DW), .NUM_INPUTS(N), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [DW-1:0] rom [8];
  logic [DW-1:0] din [4];
  always @(posedge clk) bus.w_data <= rom[bus.w_addr];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an inference is "active" with a count of accepted
  // activations and a post-phase (1 bias added, 2 result held, 3 result valid).
  bit     m_active = 0;
  int     m_cnt    = 0;
  int     m_post   = 0;
  longint m_acc    = 0;

  function automatic longint clamp(input longint v);
    if (v > 64'sd2147483647)  return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_cnt = 0; m_post = 0; m_acc = 0;
    end else if (!m_active) begin
      if (bus.start) begin
        m_active = 1; m_cnt = 0; m_post = 0; m_acc = 0;
      end
    end else if (m_post == 0) begin
      if (bus.in_valid) begin
        m_acc = clamp(m_acc + longint'($signed(bus.in_data)) * longint'($signed(rom[m_cnt])));
        m_cnt++;
        if (m_cnt == N) m_post = 1;
      end
    end else if (m_post == 1) begin
      m_acc  = clamp(m_acc + longint'($signed(bus.bias)));
      m_post = 2;
    end else if (m_post == 2) begin
      m_post = 3;
    end else begin
      m_active = 0;
    end
  end

  int          cyc = 0;
  int          ov_count = 0;
  logic [31:0] acc_hist [32];
  logic [2:0]  wa_hist  [32];
  logic        ov_hist  [32];

  always @(negedge clk) begin
    bit m_ready;
    int exp_wa;
    m_ready = m_active && (m_post == 0);
    if (!m_ready)          exp_wa = 0;
    else if (bus.in_valid) exp_wa = (m_cnt + 1 == N) ? 0 : m_cnt + 1;
    else                   exp_wa = m_cnt;
    chk("busy",      32'(bus.busy),      32'(m_active));
    chk("in_ready",  32'(bus.in_ready),  32'(m_ready));
    chk("out_valid", 32'(bus.out_valid), 32'(m_active && m_post == 3));
    chk("w_addr",    32'(bus.w_addr),    32'(exp_wa));
    chk("acc_out",   bus.acc_out,        m_acc[31:0]);
    if (bus.out_valid === 1'b1) ov_count++;
    if (cyc < 32) begin
      acc_hist[cyc] = bus.acc_out;
      wa_hist[cyc]  = bus.w_addr;
      ov_hist[cyc]  = bus.out_valid;
    end
  end

  task automatic set_data(input logic [DW-1:0] d, input logic [DW-1:0] w, input logic [31:0] b);
    for (int i = 0; i < 8; i++) rom[i] = (i < N) ? w : 16'hDEAD;
    for (int i = 0; i < 4; i++) din[i] = d;
    bus.bias = b;
  endtask

  // Entered at posedge+1; cycle k is the period following edge E(k-1), E0 samples start.
  task automatic run(input int stall_at, input int stall_len, input int ncyc,
                     input logic [31:0] start_mask, input bit rnd);
    int stalled = 0;
    for (int i = 0; i < 32; i++) begin
      acc_hist[i] = 'x; wa_hist[i] = 'x; ov_hist[i] = 1'b0;
    end
    cyc          = 0;
    bus.start    = 1'b1;
    bus.in_valid = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge clk); #1;
      cyc = k;
      if (rnd) begin
        bus.start    = ($urandom_range(0, 7) == 0);
        bus.in_valid = ($urandom_range(0, 3) != 0);
      end else begin
        bus.start = start_mask[k];
        if (m_active && m_post == 0 && m_cnt == stall_at && stalled < stall_len) begin
          bus.in_valid = 1'b0;
          stalled++;
        end else begin
          bus.in_valid = 1'b1;
        end
      end
      bus.in_data = (m_cnt < N) ? din[m_cnt] : DW'($urandom);
    end
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    int ov_before;
    int ov_win;
    bus.start = 0; bus.in_valid = 0; bus.in_data = 0; bus.bias = 0;
    set_data(16'h0100, 16'h0800, 32'h0);
    #1 rst_n = 1'b0;
    #1;
    chk("reset busy",      32'(bus.busy),      32'd0);
    chk("reset in_ready",  32'(bus.in_ready),  32'd0);
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset w_addr",    32'(bus.w_addr),    32'd0);
    chk("reset acc_out",   bus.acc_out,        32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic, no stalls
    run(-1, 0, 10, 32'h0, 1'b0);
    chk("s1 w_addr c0", 32'(wa_hist[0]), 32'd0);
    for (int k = 1; k <= 4; k++) chk("s1 w_addr seq", 32'(wa_hist[k]), 32'(k % 4));
    chk("s1 acc ACT", acc_hist[6], 32'h00200000);
    for (int k = 1; k <= 10; k++) chk("s1 out_valid cyc", 32'(ov_hist[k]), 32'(k == 7));

    // Stall of two cycles after the second accept
    run(2, 2, 12, 32'h0, 1'b0);
    chk("s2 w_addr stall a", 32'(wa_hist[3]), 32'd2);
    chk("s2 w_addr stall b", 32'(wa_hist[4]), 32'd2);
    chk("s2 acc ACT", acc_hist[8], 32'h00200000);
    for (int k = 1; k <= 12; k++) chk("s2 out_valid cyc", 32'(ov_hist[k]), 32'(k == 9));

    // Negative sum
    set_data(16'h0100, 16'hF800, 32'h00000010);
    run(-1, 0, 10, 32'h0, 1'b0);
    chk("s3 acc ACT", acc_hist[6], 32'hFFE00010);
    chk("s3 out_valid", 32'(ov_hist[7]), 32'd1);
    chk("s3 one pulse", 32'(ov_hist[8]), 32'd0);

    // Saturation
    set_data(16'h7FFF, 16'h7FFF, 32'h00001000);
    run(-1, 0, 10, 32'h0, 1'b0);
    chk("s4 acc 1", acc_hist[2], 32'h3FFF0001);
    chk("s4 acc 2", acc_hist[3], 32'h7FFE0002);
    chk("s4 acc 3", acc_hist[4], 32'h7FFFFFFF);
    chk("s4 acc 4", acc_hist[5], 32'h7FFFFFFF);
    chk("s4 acc bias", acc_hist[6], 32'h7FFFFFFF);

    // Reset mid-stream after two accepts
    set_data(16'h0100, 16'h0800, 32'h0);
    ov_before = ov_count;
    run(-1, 0, 3, 32'h0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("s5 busy async",     32'(bus.busy),     32'd0);
    chk("s5 in_ready async", 32'(bus.in_ready), 32'd0);
    chk("s5 acc async",      bus.acc_out,       32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("s5 no out_valid", 32'(ov_count - ov_before), 32'd0);
    run(-1, 0, 10, 32'h0, 1'b0);
    chk("s5 fresh acc", acc_hist[6], 32'h00200000);

    // start in ACC, BIAS and DONE is ignored; start right after DONE restarts
    run(-1, 0, 17, 32'h1A4, 1'b0);
    chk("s6 acc not cleared", acc_hist[3], 32'h00100000);
    chk("s6 acc ACT", acc_hist[6], 32'h00200000);
    ov_win = 0;
    for (int k = 1; k <= 14; k++) ov_win += int'(ov_hist[k]);
    chk("s6 single out_valid", 32'(ov_win), 32'd1);
    chk("s6 restart busy", 32'(ov_hist[15]), 32'd1);

    // Randomized runs checked by the model
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < 8; i++) rom[i] = DW'($urandom);
      for (int i = 0; i < 4; i++) din[i] = DW'($urandom);
      bus.bias = (r % 3 == 0) ? $urandom : 32'($signed(DW'($urandom)));
      run(-1, 0, 20, 32'h0, 1'b1);
      repeat (10) @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire
